// File: rtl/fft_pkg.sv
// Shared FFT definitions: controller states, stage-index width and address-width helpers
// used by the address generator, butterfly and memory blocks.
package fft_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } fft_state_e;

   localparam int FFT_STAGE_W = 5;

   function automatic int fft_aw(input int n_log2);
      return n_log2;
   endfunction

   function automatic int fft_tw_aw(input int n_log2);
      return n_log2 - 1;
   endfunction

endpackage

// File: rtl/fft_addr_calc.sv
// Combinational radix-2 DIT butterfly address map: (stage, butterfly) -> data addresses A/B
// and twiddle ROM address.
module fft_addr_calc
   import fft_pkg::*;
#(
   parameter int N_LOG2 = 10
) (
   input  logic [FFT_STAGE_W-1:0]        stage_i,
   input  logic [fft_aw(N_LOG2)-2:0]     bfly_i,
   output logic [fft_aw(N_LOG2)-1:0]     addr_a_o,
   output logic [fft_aw(N_LOG2)-1:0]     addr_b_o,
   output logic [fft_tw_aw(N_LOG2)-1:0]  tw_addr_o
);

   localparam int AW    = fft_aw(N_LOG2);
   localparam int TW_AW = fft_tw_aw(N_LOG2);

   logic [AW-1:0]          bfly;
   logic [AW-1:0]          span;
   logic [AW-1:0]          idx;
   logic [AW-1:0]          grp;
   logic [FFT_STAGE_W-1:0] tw_sh;

   // idx selects the leg within a group, grp the group; groups are 2*span apart.
   always_comb begin
      bfly      = {1'b0, bfly_i};
      span      = AW'(1) << stage_i;
      idx       = bfly & (span - AW'(1));
      grp       = bfly >> stage_i;
      tw_sh     = FFT_STAGE_W'(N_LOG2 - 1) - stage_i;
      addr_a_o  = (grp << (stage_i + FFT_STAGE_W'(1))) | idx;
      addr_b_o  = addr_a_o + span;
      tw_addr_o = TW_AW'(idx << tw_sh);
   end

endmodule

// File: rtl/fft_addr_gen.sv
// Stage/butterfly walker for the iterative radix-2 DIT FFT, one full pass per start pulse.
// Define FFT_AG_OUT_PIPE_EN for an extra output register stage stalled globally by i_READY.
module fft_addr_gen
   import fft_pkg::*;
#(
   parameter int N_LOG2 = 10
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          i_START,
   input  logic                          i_READY,
   output logic                          o_VALID,
   output logic [fft_aw(N_LOG2)-1:0]     o_ADDR_A,
   output logic [fft_aw(N_LOG2)-1:0]     o_ADDR_B,
   output logic [fft_tw_aw(N_LOG2)-1:0]  o_TW_ADDR,
   output logic [FFT_STAGE_W-1:0]        o_STAGE,
   output logic                          o_STAGE_END,
   output logic                          o_BUSY,
   output logic                          o_DONE
);

   localparam int AW    = fft_aw(N_LOG2);
   localparam int TW_AW = fft_tw_aw(N_LOG2);
   localparam logic [AW-2:0]          BFLY_LAST  = '1;
   localparam logic [FFT_STAGE_W-1:0] STAGE_LAST = FFT_STAGE_W'(N_LOG2 - 1);

   fft_state_e             state_q, state_d;
   logic [FFT_STAGE_W-1:0] stage_q, stage_d;
   logic [AW-2:0]          bfly_q, bfly_d;
   logic                   gen_vld_q, gen_vld_d;
   logic                   busy_q, done_q;

   logic [AW-1:0]          calc_a, calc_b;
   logic [TW_AW-1:0]       calc_tw;
   logic [AW-1:0]          gen_a_q, gen_b_q;
   logic [TW_AW-1:0]       gen_tw_q;
   logic                   gen_end_q;

   logic                   gen_last, gen_adv, out_xfer, out_last;

   // stage_q/bfly_q always name the butterfly held in the first register stage.
   assign gen_last = (stage_q == STAGE_LAST) && (bfly_q == BFLY_LAST);
   assign gen_adv  = gen_vld_q && i_READY;
   assign out_xfer = o_VALID && i_READY;

   always_comb begin
      state_d   = state_q;
      stage_d   = stage_q;
      bfly_d    = bfly_q;
      gen_vld_d = gen_vld_q;
      unique case (state_q)
         IDLE: begin
            if (i_START) begin
               state_d   = RUN;
               stage_d   = '0;
               bfly_d    = '0;
               gen_vld_d = 1'b1;
            end
         end
         RUN: begin
            if (gen_adv) begin
               if (gen_last) begin
                  gen_vld_d = 1'b0;
                  stage_d   = '0;
                  bfly_d    = '0;
               end else if (bfly_q == BFLY_LAST) begin
                  bfly_d  = '0;
                  stage_d = stage_q + FFT_STAGE_W'(1);
               end else begin
                  bfly_d = bfly_q + (AW-1)'(1);
               end
            end
            if (out_xfer && out_last) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= IDLE;
         stage_q   <= '0;
         bfly_q    <= '0;
         gen_vld_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         stage_q   <= stage_d;
         bfly_q    <= bfly_d;
         gen_vld_q <= gen_vld_d;
         busy_q    <= (state_d != IDLE);
         done_q    <= (state_d == DONE);
      end
   end

   fft_addr_calc #(
      .N_LOG2 (N_LOG2)
   ) u_calc (
      .stage_i   (stage_d),
      .bfly_i    (bfly_d),
      .addr_a_o  (calc_a),
      .addr_b_o  (calc_b),
      .tw_addr_o (calc_tw)
   );

   // First register stage: addresses of the next-state butterfly, zeroed when idle.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         gen_a_q   <= '0;
         gen_b_q   <= '0;
         gen_tw_q  <= '0;
         gen_end_q <= 1'b0;
      end else begin
         gen_a_q   <= gen_vld_d ? calc_a  : '0;
         gen_b_q   <= gen_vld_d ? calc_b  : '0;
         gen_tw_q  <= gen_vld_d ? calc_tw : '0;
         gen_end_q <= gen_vld_d && (bfly_d == BFLY_LAST);
      end
   end

`ifdef FFT_AG_OUT_PIPE_EN
   logic                   out_vld_q, out_end_q, out_last_q;
   logic [AW-1:0]          out_a_q, out_b_q;
   logic [TW_AW-1:0]       out_tw_q;
   logic [FFT_STAGE_W-1:0] out_stage_q;

   // Second register stage: whole pipe moves together whenever downstream is ready.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         out_vld_q   <= 1'b0;
         out_end_q   <= 1'b0;
         out_last_q  <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         out_tw_q    <= '0;
         out_stage_q <= '0;
      end else if (i_READY) begin
         out_vld_q   <= gen_vld_q;
         out_end_q   <= gen_end_q;
         out_last_q  <= gen_vld_q && gen_last;
         out_a_q     <= gen_a_q;
         out_b_q     <= gen_b_q;
         out_tw_q    <= gen_tw_q;
         out_stage_q <= stage_q;
      end
   end

   assign o_VALID     = out_vld_q;
   assign o_ADDR_A    = out_a_q;
   assign o_ADDR_B    = out_b_q;
   assign o_TW_ADDR   = out_tw_q;
   assign o_STAGE     = out_stage_q;
   assign o_STAGE_END = out_end_q;
   assign out_last    = out_last_q;
`else
   assign o_VALID     = gen_vld_q;
   assign o_ADDR_A    = gen_a_q;
   assign o_ADDR_B    = gen_b_q;
   assign o_TW_ADDR   = gen_tw_q;
   assign o_STAGE     = stage_q;
   assign o_STAGE_END = gen_end_q;
   assign out_last    = gen_last;
`endif

   assign o_BUSY = busy_q;
   assign o_DONE = done_q;

endmodule
